// File: rtl/run_tx.sv
// Serial run transmitter: drives o high for a requested number of cycles,
// then low for a fixed guard gap, counting the runs emitted.
module run_tx #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [LEN_W-1:0] in_len,
  output logic             in_ready,
  output logic             o,
  output logic             busy,
  output logic             done,
  output logic [7:0]       run_count
);

  localparam int unsigned GapW = $clog2(GAP + 1);

  typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]        count_q, count_d;
  logic              o_q, o_d;
  logic              done_q, done_d;

  assign in_ready  = (state_q == StIdle) && reset_n;
  assign busy      = (state_q != StIdle);
  assign o         = o_q;
  assign done      = done_q;
  assign run_count = count_q;

  always_comb begin
    state_d   = state_q;
    len_cnt_d = len_cnt_q;
    gap_cnt_d = gap_cnt_q;
    count_d   = count_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_len != '0) begin
            state_d   = StHigh;
            len_cnt_d = in_len;
            count_d   = count_q + 8'd1;
          end else begin
            // Zero-length request is consumed and acknowledged without a run.
            done_d = 1'b1;
          end
        end
      end
      StHigh: begin
        if (len_cnt_q == LEN_W'(1)) begin
          state_d   = StGap;
          len_cnt_d = '0;
          gap_cnt_d = GapW'(GAP);
        end else begin
          len_cnt_d = len_cnt_q - LEN_W'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(1)) begin
          state_d   = StIdle;
          gap_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    o_d = (state_d == StHigh);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      len_cnt_q <= '0;
      gap_cnt_q <= '0;
      count_q   <= '0;
      o_q       <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_cnt_q <= len_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      count_q   <= count_d;
      o_q       <= o_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_run_tx.sv
// Self-checking bench for run_tx: directed and random requests against a
// schedule-based reference model of the expected line waveform.
module tb_run_tx;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned GAP   = 1;
  localparam int          MAXC  = 4096;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [LEN_W-1:0] in_len = '0;
  logic             in_ready;
  logic             o;
  logic             busy;
  logic             done;
  logic [7:0]       run_count;

  run_tx #(.LEN_W(LEN_W), .GAP(GAP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_len    (in_len),
    .in_ready  (in_ready),
    .o         (o),
    .busy      (busy),
    .done      (done),
    .run_count (run_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per-cycle expected waveforms filled in when a request is accepted.
  bit       exp_o    [MAXC];
  bit       exp_busy [MAXC];
  bit       exp_done [MAXC];
  int       free_at = 0;
  bit [7:0] mcount  = 8'd0;
  bit       armed   = 1'b0;
  bit       prev_o  = 1'b0;
  int       rises   = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step(input logic v, input logic [LEN_W-1:0] len, input logic rn,
                      output bit accepted);
    int c;
    @(negedge clk);
    in_valid = v;
    in_len   = len;
    reset_n  = rn;
    #1;
    c = cyc;
    if (armed) begin
      chk("o", o, exp_o[c]);
      chk("busy", busy, exp_busy[c]);
      chk("done", done, exp_done[c]);
      chk("in_ready", in_ready, rn && (c >= free_at));
      chk("run_count", run_count, mcount);
      if (o && !prev_o) rises++;
      prev_o = o;
    end
    accepted = 1'b0;
    if (!rn) begin
      for (int k = c + 1; k < MAXC; k++) begin
        exp_o[k] = 0; exp_busy[k] = 0; exp_done[k] = 0;
      end
      free_at = c + 1;
      mcount  = 8'd0;
      armed   = 1'b1;
    end else if (v && c >= free_at) begin
      accepted = 1'b1;
      if (len != 0) begin
        for (int k = 1; k <= int'(len); k++) exp_o[c + k] = 1;
        for (int k = 1; k <= int'(len) + int'(GAP); k++) exp_busy[c + k] = 1;
        exp_done[c + int'(len) + int'(GAP) + 1] = 1;
        free_at = c + int'(len) + int'(GAP) + 1;
        mcount  = mcount + 8'd1;
      end else begin
        exp_done[c + 1] = 1;
        free_at = c + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, a);
  endtask

  task automatic do_reset(input int n, input logic v, input logic [LEN_W-1:0] len);
    bit a;
    for (int i = 0; i < n; i++) step(v, len, 1'b0, a);
  endtask

  // Hold the request valid until the model says it has been taken.
  task automatic send(input logic [LEN_W-1:0] len);
    bit acc = 1'b0;
    for (int n = 0; n < 64 && !acc; n++) step(1'b1, len, 1'b1, acc);
    chk("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  initial begin
    bit a;
    // Reset with a pending request, then first transfer right after release.
    do_reset(3, 1'b1, 4'd5);
    send(4'd5);
    idle(8);

    // Single run of 3.
    send(4'd3);
    idle(6);
    chk("single_count", run_count, 8'd2);

    // Back-to-back runs of 2 then 4 with valid held.
    send(4'd2);
    send(4'd4);
    idle(7);

    // Zero length followed by maximum length.
    send(4'd0);
    send(4'd15);
    idle(18);

    // Reset in the middle of a run of 8.
    send(4'd8);
    idle(3);
    step(1'b0, '0, 1'b0, a);
    idle(4);
    chk("midrun_count", run_count, 8'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), LEN_W'($urandom_range(0, 15)),
           1'($urandom_range(0, 59) != 0), a);
    end
    idle(20);

    // Counter wrap: 257 unit runs from reset.
    do_reset(1, 1'b0, '0);
    rises = 0;
    for (int i = 0; i < 257; i++) send(4'd1);
    idle(4);
    chk("wrap_count", run_count, 8'd1);
    chk("wrap_rises", rises, 257);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_tx.md
# run_tx

Serial run transmitter that drives the one-bit line a rising-edge / run detector samples. It accepts a run length over a valid/ready handshake and drives `o` high for exactly that many cycles. It then holds `o` low for a fixed guard gap, so the downstream detector returns to its idle state and sees exactly one rising edge per accepted run. A wrapping counter reports the number of runs emitted.

## Interface
Parameters:
- `LEN_W`, default 4: width of the run-length field; runs of 1..2^LEN_W-1 cycles.
- `GAP`, default 1: number of guard cycles of `o`=0 after every run. Legal range is GAP ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  run request valid.
- `in_len`  in  LEN_W  requested run length in cycles.
- `in_ready`  out  1  block can accept a request.
- `o`  out  1  serial line; registered.
- `busy`  out  1  a run or guard gap is in progress.
- `done`  out  1  one-cycle pulse; the request just completed.
- `run_count`  out  8  runs emitted since reset; wraps.

## Operation
- FSM states are IDLE, HIGH and GAP.
- Handshake: a transfer occurs on a posedge with `in_valid`=1 and `in_ready`=1. `in_len` is captured only on a transfer.
- `in_ready` = (state==IDLE) && `reset_n`; it is combinational from state. `in_valid` may be held without a transfer and is ignored outside IDLE.
- IDLE, transfer with L≥1: load the down-counter with L, go to HIGH, and increment `run_count`.
- IDLE, transfer with L=0: the request is consumed and the state stays IDLE. `o` stays 0, `run_count` is unchanged, and `done` pulses on the next cycle.
- HIGH: `o`=1. Decrement the counter each cycle. When the last run cycle is reached, load the gap counter with GAP and go to GAP.
- GAP: `o`=0. Decrement each cycle. After GAP cycles, go to IDLE and pulse `done`.
- `busy` = (state != IDLE).
- `run_count` is 8 bits and wraps modulo 256, so 255 increments to 0.
- `o`, `done` and `run_count` are registered outputs. `o` is a pure function of the registered state.

## Timing
- Reset: on any posedge with `reset_n`=0, set state=IDLE, `o`=0, `done`=0, `busy`=0, `run_count`=0, and both counters=0.
- `in_ready` is 0 while `reset_n`=0.
- Reset mid-run or mid-gap: `o` goes to 0 at that edge and the in-flight request is discarded without a `done`. A transfer is possible on the first edge after `reset_n` returns to 1.
- Transfer at edge t with L≥1:
  - `o`=1 during cycles t+1 .. t+L.
  - `o`=0 during cycles t+L+1 .. t+L+GAP.
  - Cycle t+L+GAP+1: IDLE, `in_ready`=1, `done`=1 for exactly one cycle.
- `run_count` increments and is visible from cycle t+1.
- Back-to-back requests: the next transfer can occur at the edge ending cycle t+L+GAP+1. The minimum spacing between rising edges of `o` is therefore L+GAP+1 cycles.
- Transfer at edge t with L=0: `done`=1 during cycle t+1, and `in_ready` stays 1, so consecutive zero-length requests are accepted every cycle.
- Maximum run: L = 2^LEN_W-1 (15 for the default) gives exactly 15 high cycles with no counter overflow.
- `done` and a new transfer may coincide in the same cycle; both take effect.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `in_valid`=1 and `in_len`=5 → `o`=0, `in_ready`=0, `run_count`=0 throughout. First transfer on the first edge after release.
- Single run with `in_len`=3, GAP=1, accepted at edge t → `o`=1 in cycles t+1..t+3, 0 at t+4; `done`=1 and `in_ready`=1 at t+5 only; `run_count`=1.
- Back-to-back runs: `in_valid` held high with lengths 2 then 4 → `o` pattern 0,1,1,0,0,1,1,1,1,0 from the first accept; `busy` matches the non-IDLE cycles; `run_count`=2.
- Zero length: `in_len`=0, then 15 → `o` stays 0 and `done` pulses for the zero request; the next cycle accepts 15 and `o` is high for exactly 15 cycles.
- Reset mid-run: `in_len`=8, then assert `reset_n`=0 at run cycle 4 → `o`=0 at the next edge, no `done`, `run_count`=0 after reset.
- Wrap: issue 257 runs of `in_len`=1 → `run_count` reads 255, 0, 1. A detector model fed from `o` reports exactly 257 rising edges.
